// File: rtl/dct2_row_sched_if.sv
// Row-stream bundle for dct2_row_sched: block control, input row stream,
// core hand-off and transformed row stream, grouped for one connection.
interface dct2_row_sched_if #(
    parameter int IN_W  = 288,
    parameter int OUT_W = 512
);
    logic             start;
    logic [1:0]       size;
    logic             in_valid;
    logic             in_ready;
    logic [IN_W-1:0]  in_row;
    logic [IN_W-1:0]  core_x;
    logic [1:0]       core_n;
    logic [OUT_W-1:0] core_y;
    logic             out_valid;
    logic             out_ready;
    logic [OUT_W-1:0] out_row;
    logic [4:0]       out_idx;
    logic             out_last;
    logic             busy;
    logic             done;

    // Scheduler side
    modport slave (
        input  start, size, in_valid, in_row, core_y, out_ready,
        output in_ready, core_x, core_n, out_valid, out_row, out_idx,
               out_last, busy, done
    );

    // Environment side: source of rows, the 1-D core and the row sink
    modport master (
        output start, size, in_valid, in_row, core_y, out_ready,
        input  in_ready, core_x, core_n, out_valid, out_row, out_idx,
               out_last, busy, done
    );
endinterface

// File: rtl/dct2_row_sched.sv
// Row scheduler for a 2-D DCT: streams the rows of a 4/8/16/32-row block
// through an external combinational 1-D core using a two-stage pipeline
// (stage A holds the core operand, stage B the registered core result).
module dct2_row_sched #(
    parameter int IN_W  = 288,
    parameter int OUT_W = 512
) (
    input  logic            clk,
    input  logic            rst_n,
    dct2_row_sched_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        FLUSH = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t           state;
    logic [1:0]       size_q;
    logic [5:0]       in_cnt;
    logic [5:0]       out_cnt;
    logic             busy_q;
    logic             done_q;

    // Stage A: operand presented to the core
    logic [IN_W-1:0]  core_x_q;
    logic             a_valid;
    logic [4:0]       a_idx;

    // Stage B: registered core result
    logic [OUT_W-1:0] out_row_q;
    logic             out_valid_q;
    logic [4:0]       out_idx_q;

    logic [5:0]       rows;
    logic [5:0]       last_idx;
    logic             advance;
    logic             in_ready_c;
    logic             accept;
    logic             out_hs;
    logic             out_last_c;

    // Rows per block follow the latched size code: 4, 8, 16 or 32
    assign rows     = 6'd4 << size_q;
    assign last_idx = rows - 6'd1;

    // Stage A moves into B whenever B is empty or being drained this cycle
    assign advance    = a_valid && (!out_valid_q || bus.out_ready);
    assign in_ready_c = (state == RUN) && (in_cnt < rows) && (!a_valid || advance);
    assign accept     = bus.in_valid && in_ready_c;
    assign out_hs     = out_valid_q && bus.out_ready;
    assign out_last_c = out_valid_q && ({1'b0, out_idx_q} == last_idx);

    // Block-level control: state, size latch, row counters, busy/done flags
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            size_q  <= 2'b00;
            in_cnt  <= 6'd0;
            out_cnt <= 6'd0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            if (accept) begin
                in_cnt <= in_cnt + 6'd1;
            end
            if (out_hs) begin
                out_cnt <= out_cnt + 6'd1;
            end
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        state   <= RUN;
                        size_q  <= bus.size;
                        in_cnt  <= 6'd0;
                        out_cnt <= 6'd0;
                        busy_q  <= 1'b1;
                    end
                end
                RUN: begin
                    // All rows taken in; remaining work is draining the pipe
                    if (in_cnt == rows) begin
                        state <= FLUSH;
                    end
                end
                FLUSH: begin
                    if (out_hs && out_last_c) begin
                        state  <= DONE;
                        done_q <= 1'b1;
                    end
                end
                DONE: begin
                    state  <= IDLE;
                    done_q <= 1'b0;
                    busy_q <= 1'b0;
                end
                default: begin
                    state  <= IDLE;
                    done_q <= 1'b0;
                    busy_q <= 1'b0;
                end
            endcase
        end
    end

    // Stage A: capture an accepted row for the core, release it when B takes it
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            core_x_q <= '0;
            a_valid  <= 1'b0;
            a_idx    <= 5'd0;
        end else begin
            if (accept) begin
                core_x_q <= bus.in_row;
                a_idx    <= in_cnt[4:0];
                a_valid  <= 1'b1;
            end else if (advance) begin
                a_valid  <= 1'b0;
            end
        end
    end

    // Stage B: register the core result; hold it steady while downstream stalls
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_row_q   <= '0;
            out_idx_q   <= 5'd0;
            out_valid_q <= 1'b0;
        end else begin
            if (advance) begin
                out_row_q   <= bus.core_y;
                out_idx_q   <= a_idx;
                out_valid_q <= 1'b1;
            end else if (out_hs) begin
                out_valid_q <= 1'b0;
            end
        end
    end

    assign bus.in_ready  = in_ready_c;
    assign bus.core_x    = core_x_q;
    assign bus.core_n    = size_q;
    assign bus.out_valid = out_valid_q;
    assign bus.out_row   = out_row_q;
    assign bus.out_idx   = out_idx_q;
    assign bus.out_last  = out_last_c;
    assign bus.busy      = busy_q;
    assign bus.done      = done_q;

endmodule

// File: tb/tb_dct2_row_sched.sv
// Bench for dct2_row_sched: models the 1-D core, feeds random rows and
// compares the transformed row stream against a block-level reference.
module tb_dct2_row_sched;

    localparam int IN_W  = 288;
    localparam int OUT_W = 512;

    typedef struct {
        logic [OUT_W-1:0] row;
        int               idx;
        bit               last;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    dct2_row_sched_if #(.IN_W(IN_W), .OUT_W(OUT_W)) bus ();

    dct2_row_sched #(.IN_W(IN_W), .OUT_W(OUT_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    int ordy_mode = 0;      // 0: ready, 1: toggle, 2: stalled, 3: random
    int blk_rows = 0;
    int blk_idx  = 0;
    int acc_total = 0;
    int hs_total  = 0;
    int done_cnt  = 0;
    exp_t exp_q[$];
    int   acc_cyc[$];
    int   hs_cyc[$];

    // Stand-in for the 1-D core: any fixed per-coefficient mapping of row and size
    function automatic logic [OUT_W-1:0] core_f(input logic [IN_W-1:0] x, input logic [1:0] n);
        logic [OUT_W-1:0] y;
        logic signed [8:0] s;
        y = '0;
        for (int k = 0; k < 32; k++) begin
            s = x[9*k +: 9];
            y[16*k +: 16] = 16'(s * (k + 1)) + 16'(n) * 16'd7 - 16'(k);
        end
        return y;
    endfunction

    assign bus.core_y = core_f(bus.core_x, bus.core_n);

    task automatic chk(input string tag, input logic [OUT_W-1:0] got, input logic [OUT_W-1:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [IN_W-1:0] rand_row();
        logic [IN_W-1:0] r;
        for (int j = 0; j < 9; j++) r[32*j +: 32] = $urandom;
        return r;
    endfunction

    // Downstream ready pattern
    initial begin
        bus.out_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            case (ordy_mode)
                0: bus.out_ready = 1'b1;
                1: bus.out_ready = ~bus.out_ready;
                2: bus.out_ready = 1'b0;
                default: bus.out_ready = 1'($urandom_range(0, 1));
            endcase
        end
    end

    always @(posedge clk) cyc <= cyc + 1;

    // Output monitor: scoreboard, stall stability and done placement
    bit               stall_prev = 0;
    bit               last_hs_prev = 0;
    logic [OUT_W-1:0] stall_row;
    logic [4:0]       stall_idx;
    always @(negedge clk) begin
        if (!rst_n) begin
            stall_prev   = 0;
            last_hs_prev = 0;
        end else begin
            if (stall_prev) begin
                chk("stall_valid", OUT_W'(bus.out_valid), OUT_W'(1));
                chk("stall_row", bus.out_row, stall_row);
                chk("stall_idx", OUT_W'(bus.out_idx), OUT_W'(stall_idx));
            end
            if (bus.done) begin
                chk("done_after_last", OUT_W'(last_hs_prev), OUT_W'(1));
                done_cnt++;
            end
            last_hs_prev = 0;
            if (bus.out_valid && bus.out_ready) begin
                hs_total++;
                hs_cyc.push_back(cyc);
                if (exp_q.size() == 0) begin
                    chk("unexpected_out", OUT_W'(bus.out_idx), OUT_W'(32));
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    chk("out_row", bus.out_row, e.row);
                    chk("out_idx", OUT_W'(bus.out_idx), OUT_W'(e.idx));
                    chk("out_last", OUT_W'(bus.out_last), OUT_W'(e.last));
                end
                last_hs_prev = bus.out_last;
            end
            stall_prev = bus.out_valid && !bus.out_ready;
            stall_row  = bus.out_row;
            stall_idx  = bus.out_idx;
        end
    end

    task automatic start_block(input logic [1:0] s);
        blk_rows = 4 << s;
        blk_idx  = 0;
        bus.start = 1'b1;
        bus.size  = s;
        step();
        bus.start = 1'b0;
        bus.size  = 2'b00;
    endtask

    // Offer n rows, optionally with random idle gaps; record what was accepted
    task automatic feed(input int n, input int gap_pct);
        bit acc;
        int g;
        for (int i = 0; i < n; i++) begin
            while ($urandom_range(0, 99) < gap_pct) begin
                bus.in_valid = 1'b0;
                step();
            end
            bus.in_valid = 1'b1;
            bus.in_row   = rand_row();
            g = 0;
            do begin
                @(negedge clk);
                acc = bus.in_ready;
                if (acc) begin
                    exp_t e;
                    e.row  = core_f(bus.in_row, 2'(blk_rows == 4 ? 0 : blk_rows == 8 ? 1 : blk_rows == 16 ? 2 : 3));
                    e.idx  = blk_idx;
                    e.last = (blk_idx == blk_rows - 1);
                    exp_q.push_back(e);
                    acc_cyc.push_back(cyc);
                    blk_idx++;
                    acc_total++;
                end
                @(posedge clk);
                #1;
                g++;
            end while (!acc && g < 300);
            if (!acc) begin
                chk("feed_timeout", OUT_W'(0), OUT_W'(1));
                bus.in_valid = 1'b0;
                return;
            end
        end
        bus.in_valid = 1'b0;
    endtask

    task automatic wait_done(input string tag);
        int d0;
        int g;
        d0 = done_cnt;
        g = 0;
        while (done_cnt == d0 && g < 3000) begin
            step();
            g++;
        end
        chk({tag, "_done_seen"}, OUT_W'(done_cnt > d0), OUT_W'(1));
        repeat (4) step();
        chk({tag, "_done_once"}, OUT_W'(done_cnt), OUT_W'(d0 + 1));
        chk({tag, "_all_rows_out"}, OUT_W'(exp_q.size()), OUT_W'(0));
        chk({tag, "_idle_after"}, OUT_W'(bus.busy), OUT_W'(0));
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_in_ready"}, OUT_W'(bus.in_ready), OUT_W'(0));
        chk({tag, "_out_valid"}, OUT_W'(bus.out_valid), OUT_W'(0));
        chk({tag, "_out_last"}, OUT_W'(bus.out_last), OUT_W'(0));
        chk({tag, "_busy"}, OUT_W'(bus.busy), OUT_W'(0));
        chk({tag, "_done"}, OUT_W'(bus.done), OUT_W'(0));
        chk({tag, "_core_x"}, OUT_W'(bus.core_x), OUT_W'(0));
        chk({tag, "_out_row"}, bus.out_row, OUT_W'(0));
        chk({tag, "_out_idx"}, OUT_W'(bus.out_idx), OUT_W'(0));
        chk({tag, "_core_n"}, OUT_W'(bus.core_n), OUT_W'(0));
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int a0;
        int h0;
        bus.start = 1'b0;
        bus.size = 2'b00;
        bus.in_valid = 1'b1;
        bus.in_row = rand_row();

        // Reset values, with in_valid asserted during reset
        repeat (3) step();
        chk_reset_vals("rst");
        rst_n = 1'b1;
        step();

        // in_valid in IDLE without start
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("idle_in_ready", OUT_W'(bus.in_ready), OUT_W'(0));
            chk("idle_out_valid", OUT_W'(bus.out_valid), OUT_W'(0));
            chk("idle_busy", OUT_W'(bus.busy), OUT_W'(0));
        end
        step();
        bus.in_valid = 1'b0;
        step();

        // 4-row block, back to back, downstream always ready
        ordy_mode = 0;
        step();
        acc_cyc.delete();
        hs_cyc.delete();
        start_block(2'b00);
        @(negedge clk);
        chk("run_busy", OUT_W'(bus.busy), OUT_W'(1));
        chk("run_core_n4", OUT_W'(bus.core_n), OUT_W'(0));
        step();
        feed(4, 0);
        wait_done("b4");
        chk("b4_hs_count", OUT_W'(hs_cyc.size()), OUT_W'(4));
        if (hs_cyc.size() == 4 && acc_cyc.size() == 4) begin
            for (int i = 0; i < 4; i++)
                chk("b4_latency", OUT_W'(hs_cyc[i]), OUT_W'(acc_cyc[0] + 2 + i));
        end

        // 32-row block with toggling downstream ready
        ordy_mode = 1;
        start_block(2'b11);
        feed(32, 0);
        wait_done("b32");

        // 8-row block with downstream stalled for a while
        ordy_mode = 2;
        repeat (2) step();
        a0 = acc_total;
        start_block(2'b01);
        fork
            feed(8, 0);
        join_none
        repeat (5) step();
        @(negedge clk);
        chk("stall_accepts_le2", OUT_W'((acc_total - a0) <= 2), OUT_W'(1));
        chk("stall_in_ready_low", OUT_W'(bus.in_ready), OUT_W'(0));
        step();
        ordy_mode = 0;
        wait_done("b8stall");

        // start during RUN is ignored
        start_block(2'b01);
        fork
            feed(8, 0);
        join_none
        repeat (2) step();
        bus.start = 1'b1;
        bus.size  = 2'b11;
        step();
        bus.start = 1'b0;
        bus.size  = 2'b00;
        @(negedge clk);
        chk("restart_core_n", OUT_W'(bus.core_n), OUT_W'(1));
        step();
        wait_done("b8restart");

        // Reset in the middle of a block
        start_block(2'b01);
        feed(3, 0);
        rst_n = 1'b0;
        #2;
        chk_reset_vals("midrst");
        exp_q.delete();
        blk_idx = 0;
        step();
        rst_n = 1'b1;
        step();
        h0 = hs_total;
        bus.in_valid = 1'b1;
        repeat (6) step();
        bus.in_valid = 1'b0;
        chk("postrst_no_out", OUT_W'(hs_total), OUT_W'(h0));
        chk("postrst_idle", OUT_W'(bus.busy), OUT_W'(0));
        start_block(2'b01);
        feed(8, 0);
        wait_done("b8fresh");

        // Random blocks: random size, input gaps and downstream ready
        ordy_mode = 3;
        for (int b = 0; b < 5; b++) begin
            logic [1:0] s;
            s = 2'($urandom_range(0, 3));
            start_block(s);
            feed(4 << s, 30);
            wait_done("rnd");
        end
        ordy_mode = 0;
        repeat (3) step();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
